// File: rtl/dest_control.sv
// dest_control: destination side of a four-phase request/ack CDC handshake.
// Define DEST_CTRL_SYNC3_EN for a 3-flop request synchroniser (default: 2 flops).
module dest_control #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_d,
  input  logic             rst_n,
  input  logic             request,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             ack,
  output logic [WIDTH-1:0] d_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count
);
  typedef enum logic [1:0] {IDLE, ACK_HI, ACK_LO_WAIT} state_t;
  state_t state, state_n;
  logic req_s1, req_s2, req_sync, ack_n, dv_n;
  logic [WIDTH-1:0] d_n;
  logic [CNT_W-1:0] cnt_n;
`ifdef DEST_CTRL_SYNC3_EN
  logic req_s3;
  always_ff @(posedge clk_d) req_s3 <= rst_n ? req_s2 : 1'b0;
  assign req_sync = req_s3;
`else
  assign req_sync = req_s2;
`endif
  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      req_s1     <= 1'b0;
      req_s2     <= 1'b0;
      state      <= IDLE;
      ack        <= 1'b0;
      d_out      <= '0;
      data_valid <= 1'b0;
      xfer_count <= '0;
    end else begin
      req_s1     <= request;
      req_s2     <= req_s1;
      state      <= state_n;
      ack        <= ack_n;
      d_out      <= d_n;
      data_valid <= dv_n;
      xfer_count <= cnt_n;
    end
  end
  // ready only gates the IDLE capture; ACK_LO_WAIT forces one ack-low cycle between transfers
  always_comb begin
    state_n = state;
    ack_n   = ack;
    d_n     = d_out;
    dv_n    = 1'b0;
    cnt_n   = xfer_count;
    case (state)
      IDLE: if (req_sync && ready) begin
        state_n = ACK_HI;
        ack_n   = 1'b1;
        d_n     = data_in;
        dv_n    = 1'b1;
      end
      ACK_HI: if (!req_sync) begin
        state_n = ACK_LO_WAIT;
        ack_n   = 1'b0;
        cnt_n   = xfer_count + CNT_W'(1);
      end
      ACK_LO_WAIT: state_n = IDLE;
      default: begin
        state_n = IDLE;
        ack_n   = 1'b0;
      end
    endcase
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_dest_control.sv
// tb_dest_control: table-driven transfers with a data scoreboard, plus reset and wrap sequences.
module tb_dest_control;
`ifdef DEST_CTRL_SYNC3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk_d = 1'b0, rst_n, request, ready;
  logic [7:0] data_in, d_out, w_d_out;
  logic ack, data_valid, busy, w_ack, w_dv, w_busy;
  logic [7:0] xfer_count;
  logic [1:0] w_count;
  int checks = 0, errors = 0;
  logic [7:0] sb[$];
  logic prev_dv = 1'b0;

  always #5 clk_d = ~clk_d;

  dest_control #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_d(clk_d), .rst_n(rst_n), .request(request), .data_in(data_in), .ready(ready),
    .ack(ack), .d_out(d_out), .data_valid(data_valid), .busy(busy), .xfer_count(xfer_count));

  dest_control #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk_d(clk_d), .rst_n(rst_n), .request(request), .data_in(data_in), .ready(ready),
    .ack(w_ack), .d_out(w_d_out), .data_valid(w_dv), .busy(w_busy), .xfer_count(w_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_d);
    #1;
  endtask

  // scoreboard: every data_valid pulse must deliver the oldest pending word, and last one cycle
  always @(posedge clk_d) begin
    #1;
    if (data_valid) begin
      chk("dv_single", {31'b0, prev_dv}, 32'd0);
      if (sb.size() == 0) chk("sb_unexpected", {24'b0, d_out}, 32'hFFFF_FFFF);
      else chk("sb_data", {24'b0, d_out}, {24'b0, sb.pop_front()});
    end
    prev_dv = data_valid;
  end

  task automatic xfer(input logic [7:0] d, input int bp);
    data_in = d;
    ready   = (bp == 0);
    request = 1'b1;
    sb.push_back(d);
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        step();
        chk("bp_ack", {31'b0, ack}, 32'd0);
        chk("bp_dv", {31'b0, data_valid}, 32'd0);
      end
      ready = 1'b1;
      step();
    end else begin
      for (int i = 0; i < LAT; i++) begin
        step();
        chk("lat_ack", {31'b0, ack}, 32'd0);
      end
      step();
    end
    chk("ack_hi", {31'b0, ack}, 32'd1);
    chk("busy_hi", {31'b0, busy}, 32'd1);
    chk("dv_hi", {31'b0, data_valid}, 32'd1);
    chk("d_out", {24'b0, d_out}, {24'b0, d});
    ready   = 1'b0;
    request = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      step();
      chk("rel_ack_hold", {31'b0, ack}, 32'd1);
    end
    step();
    chk("rel_ack_lo", {31'b0, ack}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         bp;
    logic [7:0] exp_cnt;
    logic [1:0] exp_wrap;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 0,  8'd2, 2'd2};
    vecs[1] = '{8'h5A, 10, 8'd3, 2'd3};
    vecs[2] = '{8'h01, 0,  8'd4, 2'd0};
    vecs[3] = '{8'h02, 0,  8'd5, 2'd1};
    vecs[4] = '{8'h03, 0,  8'd6, 2'd2};
    vecs[5] = '{8'h04, 0,  8'd7, 2'd3};
    vecs[6] = '{8'hC3, 6,  8'd8, 2'd0};
    vecs[7] = '{8'h7E, 0,  8'd9, 2'd1};
    rst_n = 1'b0; request = 1'b1; ready = 1'b1; data_in = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_dout", {24'b0, d_out}, 32'd0);
      chk("rst_dv", {31'b0, data_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_cnt", {24'b0, xfer_count}, 32'd0);
      chk("rst_wcnt", {30'b0, w_count}, 32'd0);
    end
    sb.push_back(8'h3C);
    rst_n = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      step();
      chk("post_rst_ack", {31'b0, ack}, 32'd0);
    end
    step();
    chk("post_rst_ack_hi", {31'b0, ack}, 32'd1);
    chk("post_rst_dout", {24'b0, d_out}, 32'h3C);
    request = 1'b0;
    for (int i = 0; i <= LAT; i++) step();
    chk("first_ack_lo", {31'b0, ack}, 32'd0);
    chk("first_cnt", {24'b0, xfer_count}, 32'd1);
    chk("first_busy", {31'b0, busy}, 32'd1);
    step();
    chk("first_idle", {31'b0, busy}, 32'd0);
    for (int v = 0; v < 8; v++) begin
      xfer(vecs[v].data, vecs[v].bp);
      chk("cnt", {24'b0, xfer_count}, {24'b0, vecs[v].exp_cnt});
      chk("wrap_cnt", {30'b0, w_count}, {30'b0, vecs[v].exp_wrap});
    end
    step();
    data_in = 8'h99; ready = 1'b1; request = 1'b1;
    sb.push_back(8'h99);
    for (int i = 0; i <= LAT; i++) step();
    chk("mid_ack_hi", {31'b0, ack}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_ack", {31'b0, ack}, 32'd0);
    chk("mid_rst_dout", {24'b0, d_out}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_cnt", {24'b0, xfer_count}, 32'd0);
    rst_n = 1'b1; data_in = 8'h66;
    sb.push_back(8'h66);
    for (int i = 0; i < LAT; i++) begin
      step();
      chk("resync_ack", {31'b0, ack}, 32'd0);
    end
    step();
    chk("resync_ack_hi", {31'b0, ack}, 32'd1);
    chk("resync_dout", {24'b0, d_out}, 32'h66);
    request = 1'b0;
    for (int i = 0; i <= LAT + 1; i++) step();
    chk("end_cnt", {24'b0, xfer_count}, 32'd1);
    chk("end_busy", {31'b0, busy}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
